// File: rtl/mure_pkg.sv
// Shared core types: commit-port micro-op entries and the trace packet
// that the commit serializer buffers for the trace encoder.
package mure_pkg;

   localparam int XLEN            = 32;
   localparam int CAUSE_LEN       = 5;
   localparam int ITYPE_LEN       = 3;
   localparam int NR_COMMIT_PORTS = 2;

   localparam logic [ITYPE_LEN-1:0] ITYPE_STANDARD  = 3'd0;
   localparam logic [ITYPE_LEN-1:0] ITYPE_EXCEPTION = 3'd1;
   localparam logic [ITYPE_LEN-1:0] ITYPE_INTERRUPT = 3'd2;

   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      pc;
      logic [ITYPE_LEN-1:0] itype;
   } uop_entry_s;

   typedef struct packed {
      uop_entry_s           uop;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
   } trace_pkt_s;

   // Exceptions and interrupts carry cause/tval even without a retiring uop.
   function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
      return (itype == ITYPE_EXCEPTION) || (itype == ITYPE_INTERRUPT);
   endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace packet FIFO: up to two in-order writes and one read per cycle,
// head slot read combinationally so a push is visible one cycle later.
module trace_fifo_2w1r
   import mure_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic [1:0]       wr_cnt_i,
   input  trace_pkt_s [1:0] wr_data_i,
   input  logic             rd_en_i,
   output trace_pkt_s       rd_data_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = $clog2(DEPTH);

   trace_pkt_s mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   always_comb begin
      wr_ptr_next = wr_ptr_reg + PW'(wr_cnt_i);
      rd_ptr_next = rd_ptr_reg + PW'(rd_en_i);
      count_next  = count_reg + CW'(wr_cnt_i) - CW'(rd_en_i);
      if (flush_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage is never reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 2; i++) begin
         if (!flush_i && (wr_cnt_i > 2'(i))) begin
            mem[wr_ptr_reg + PW'(i)] <= wr_data_i[i];
         end
      end
   end

   assign rd_data_o = mem[rd_ptr_reg];
   assign count_o   = count_reg;

endmodule

// File: rtl/commit_serializer.sv
// Serializes the two commit ports into a single in-order trace stream,
// dropping the youngest entries when the buffer cannot absorb them.
module commit_serializer
   import mure_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  uop_entry_s [NR_COMMIT_PORTS-1:0]     uop_entry_i,
   input  logic [CAUSE_LEN-1:0]                 cause_i,
   input  logic [XLEN-1:0]                      tval_i,
   input  logic                                 ready_i,
   output logic                                 valid_o,
   output uop_entry_s                           uop_entry_o,
   output logic [CAUSE_LEN-1:0]                 cause_o,
   output logic [XLEN-1:0]                      tval_o,
   output logic [$clog2(DEPTH):0]               count_o,
   output logic                                 full_o,
   output logic                                 overflow_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [NR_COMMIT_PORTS-1:0] active;
   trace_pkt_s [1:0]           port_pkt;
   trace_pkt_s [1:0]           wr_data;
   trace_pkt_s                 head;
   logic [CW-1:0]              count;
   logic [CW:0]                capacity;
   logic [1:0]                 n_active;
   logic [1:0]                 n_push;
   logic                       pop;
   logic                       drop;
   logic                       overflow_reg, overflow_next;

   genvar gi;
   generate
      for (gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_port
         assign active[gi]   = uop_entry_i[gi].valid || is_trap(uop_entry_i[gi].itype);
         assign port_pkt[gi] = '{
            uop:   uop_entry_i[gi],
            cause: is_trap(uop_entry_i[gi].itype) ? cause_i : '0,
            tval:  is_trap(uop_entry_i[gi].itype) ? tval_i  : '0
         };
      end
   endgenerate

   assign valid_o = (count != '0);
   assign pop     = valid_o && ready_i;

   // Compact active ports toward slot 0 and clip to the free space, which
   // includes the slot released by a same-cycle pop.
   always_comb begin
      wr_data  = port_pkt;
      if (!active[0]) begin
         wr_data[0] = port_pkt[1];
      end
      n_active = {1'b0, active[0]} + {1'b0, active[1]};
      capacity = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
      n_push   = n_active;
      drop     = 1'b0;
      if (flush_i) begin
         n_push = '0;
      end else if ((CW+1)'(n_active) > capacity) begin
         n_push = capacity[1:0];
         drop   = 1'b1;
      end
   end

   trace_fifo_2w1r #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .wr_cnt_i  (n_push),
      .wr_data_i (wr_data),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .count_o   (count)
   );

   assign overflow_next = overflow_reg || drop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= overflow_next;
      end
   end

   assign uop_entry_o = valid_o ? head.uop   : '0;
   assign cause_o     = valid_o ? head.cause : '0;
   assign tval_o      = valid_o ? head.tval  : '0;
   assign count_o     = count;
   assign full_o      = (count > CW'(DEPTH - 2));
   assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_commit_serializer.sv
// Randomized and directed check of commit_serializer against a queue-based
// model of the commit stream.
module tb_commit_serializer;
   import mure_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       flush = 1'b0;
   uop_entry_s [1:0]           uop_in = '0;
   logic [CAUSE_LEN-1:0]       cause_in = '0;
   logic [XLEN-1:0]            tval_in = '0;
   logic                       ready = 1'b0;
   logic                       valid_o;
   uop_entry_s                 uop_entry_o;
   logic [CAUSE_LEN-1:0]       cause_o;
   logic [XLEN-1:0]            tval_o;
   logic [CW-1:0]              count_o;
   logic                       full_o;
   logic                       overflow_o;

   int n_cmp = 0;
   int n_err = 0;

   trace_pkt_s model_q[$];
   logic       model_ovf = 1'b0;

   commit_serializer #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .uop_entry_i (uop_in),
      .cause_i     (cause_in),
      .tval_i      (tval_in),
      .ready_i     (ready),
      .valid_o     (valid_o),
      .uop_entry_o (uop_entry_o),
      .cause_o     (cause_o),
      .tval_o      (tval_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic uop_entry_s mk(input logic v, input logic [XLEN-1:0] pc,
                                     input logic [ITYPE_LEN-1:0] it);
      uop_entry_s u;
      u.valid = v;
      u.pc    = pc;
      u.itype = it;
      return u;
   endfunction

   function automatic logic trap_type(input logic [ITYPE_LEN-1:0] it);
      return (it == 3'd1) || (it == 3'd2);
   endfunction

   // Model: pop the head if presented and accepted, then append each active
   // port in age order while there is room; anything left over is lost.
   task automatic model_update();
      trace_pkt_s p;
      if (flush) begin
         model_q.delete();
         return;
      end
      if (model_q.size() > 0 && ready) void'(model_q.pop_front());
      for (int i = 0; i < 2; i++) begin
         if (uop_in[i].valid || trap_type(uop_in[i].itype)) begin
            p.uop   = uop_in[i];
            p.cause = trap_type(uop_in[i].itype) ? cause_in : '0;
            p.tval  = trap_type(uop_in[i].itype) ? tval_in  : '0;
            if (model_q.size() < DEPTH) model_q.push_back(p);
            else                         model_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      trace_pkt_s h = '0;
      int         sz = model_q.size();
      if (sz > 0) h = model_q[0];
      check_eq({tag, ".valid"}, 64'(valid_o), 64'(sz > 0));
      check_eq({tag, ".uop"},   64'(uop_entry_o), 64'(h.uop));
      check_eq({tag, ".cause"}, 64'(cause_o), 64'(h.cause));
      check_eq({tag, ".tval"},  64'(tval_o), 64'(h.tval));
      check_eq({tag, ".count"}, 64'(count_o), 64'(sz));
      check_eq({tag, ".full"},  64'(full_o), 64'((DEPTH - sz) < 2));
      check_eq({tag, ".ovf"},   64'(overflow_o), 64'(model_ovf));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_update();
      check_outputs(tag);
      $display("cyc %s: valid=%0b pc=0x%0h count=%0d ovf=%0b", tag, valid_o,
               uop_entry_o.pc, count_o, overflow_o);
   endtask

   task automatic drive(input logic v0, input logic [XLEN-1:0] pc0, input logic [2:0] it0,
                        input logic v1, input logic [XLEN-1:0] pc1, input logic [2:0] it1,
                        input logic [CAUSE_LEN-1:0] c, input logic [XLEN-1:0] t);
      uop_in[0] = mk(v0, pc0, it0);
      uop_in[1] = mk(v1, pc1, it1);
      cause_in  = c;
      tval_in   = t;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      flush = 1'b0;
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      check_outputs(tag);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset state, checked without any clock edge
      #2;
      check_outputs("reset");
      #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // Dual valid commit drains in order with latency 1
      ready = 1'b1;
      drive(1, 32'h100, 0, 1, 32'h104, 0, 0, 0);
      step("dual0");
      check_eq("dual0.pc", 64'(uop_entry_o.pc), 64'h100);
      idle();
      step("dual1");
      check_eq("dual1.pc", 64'(uop_entry_o.pc), 64'h104);
      step("dual2");
      check_eq("dual2.valid", 64'(valid_o), 64'h0);

      // Lone exception on port 1
      drive(0, 32'h0, 0, 0, 32'h300, 3'd1, 5'd2, 32'hDEAD);
      ready = 1'b0;
      step("exc");
      check_eq("exc.cause", 64'(cause_o), 64'h2);
      check_eq("exc.tval",  64'(tval_o), 64'hDEAD);
      check_eq("exc.count", 64'(count_o), 64'h1);
      ready = 1'b1;
      idle();
      step("exc_pop");

      // Fill without draining, then overflow
      ready = 1'b0;
      drive(1, 32'h10, 0, 1, 32'h14, 0, 0, 0);
      step("fill0");
      drive(1, 32'h18, 0, 1, 32'h1C, 0, 0, 0);
      step("fill1");
      check_eq("fill1.full", 64'(full_o), 64'h1);
      drive(1, 32'h20, 0, 1, 32'h24, 0, 0, 0);
      step("fill2");
      check_eq("fill2.ovf", 64'(overflow_o), 64'h1);
      check_eq("fill2.pc",  64'(uop_entry_o.pc), 64'h10);

      // Flush keeps the sticky overflow and discards same-cycle pushes
      idle();
      flush = 1'b1;
      step("flush0");
      flush = 1'b0;
      drive(1, 32'h40, 0, 1, 32'h44, 0, 0, 0);
      step("flush_fill");
      flush = 1'b1;
      drive(1, 32'h48, 0, 1, 32'h4C, 0, 0, 0);
      step("flush1");
      check_eq("flush1.count", 64'(count_o), 64'h0);
      check_eq("flush1.ovf",   64'(overflow_o), 64'h1);
      idle();

      // Count 3 with a pop absorbs a dual push
      pulse_reset("rst_a");
      drive(1, 32'h50, 0, 1, 32'h54, 0, 0, 0);
      step("c3a");
      drive(1, 32'h58, 0, 0, 32'h0, 0, 0, 0);
      step("c3b");
      ready = 1'b1;
      drive(1, 32'h60, 0, 1, 32'h64, 0, 0, 0);
      step("c3c");
      check_eq("c3c.count", 64'(count_o), 64'h4);
      check_eq("c3c.ovf",   64'(overflow_o), 64'h0);

      // Reset mid-stream, then a fresh push
      ready = 1'b0;
      idle();
      step("pre_rst");
      pulse_reset("rst_b");
      drive(1, 32'h200, 0, 0, 32'h0, 0, 0, 0);
      step("post_rst");
      check_eq("post_rst.pc", 64'(uop_entry_o.pc), 64'h200);
      idle();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         logic [2:0] it0, it1;
         it0 = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 4));
         it1 = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 4));
         drive(1'($urandom), $urandom, it0, 1'($urandom), $urandom, it1,
               5'($urandom), $urandom);
         ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 29) == 0);
         step($sformatf("rnd%0d", n));
         if ($urandom_range(0, 79) == 0) pulse_reset($sformatf("rnd_rst%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
